// File: rtl/alu_result_stage.sv
// 4-bit add result stage: Z/C/V/N flags, 2-entry FIFO with valid/ready, pop counter, sticky overflow.
// Optional feature: define ALU_RES_SAT_EN for signed saturation of the result on overflow.
module alu_result_stage #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       AMod,
  input  logic [3:0]       BMod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       Res,
  output logic [3:0]       Flags,
  input  logic             clr_sticky,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] op_cnt
);

  localparam int unsigned DATA_W = 4;
  localparam int unsigned DEPTH  = 2;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              z;
    logic              c;
    logic              v;
    logic              n;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  entry_t            mem [DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push;
  logic              pop;
  logic [DATA_W:0]   sum5;
  logic [DATA_W-1:0] r_wrap;
  logic [DATA_W-1:0] r_fin;
  logic              v_raw;
  entry_t            new_entry;

  // Adder and flag derivation for the incoming operand pair
  always_comb begin
    sum5   = {1'b0, AMod} + {1'b0, BMod};
    r_wrap = sum5[DATA_W-1:0];
    v_raw  = (AMod[3] == BMod[3]) && (r_wrap[3] != AMod[3]);
    r_fin  = r_wrap;
`ifdef ALU_RES_SAT_EN
    if (v_raw) begin
      r_fin = AMod[3] ? 4'b1000 : 4'b0111;
    end
`endif
    new_entry.res = r_fin;
    new_entry.z   = (r_fin == 4'b0000);
    new_entry.c   = sum5[DATA_W];
    new_entry.v   = v_raw;
    new_entry.n   = r_fin[3];
  end

  // Occupancy FSM and handshake/head decode from registered state
  always_comb begin
    state_d   = state_q;
    in_ready  = (state_q != FULL);
    out_valid = (state_q != EMPTY);
    push      = in_valid && (state_q != FULL);
    pop       = out_ready && (state_q != EMPTY);
    Res       = '0;
    Flags     = '0;
    if (state_q != EMPTY) begin
      Res   = mem[rd_ptr].res;
      Flags = {mem[rd_ptr].z, mem[rd_ptr].c, mem[rd_ptr].v, mem[rd_ptr].n};
    end
    case (state_q)
      EMPTY:   if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      op_cnt     <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        op_cnt <= op_cnt + CNT_W'(1);
      end
      // Set has priority over clear
      if (push && new_entry.v) ovf_sticky <= 1'b1;
      else if (clr_sticky)     ovf_sticky <= 1'b0;
    end
  end

  // Storage needs no reset: entries are only visible while occupied
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized + directed bench for alu_result_stage against a queue-based arithmetic model.
module tb_alu_result_stage;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       AMod;
  logic [3:0]       BMod;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       Res;
  logic [3:0]       Flags;
  logic             clr_sticky;
  logic             ovf_sticky;
  logic [CNT_W-1:0] op_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int res;
    int flags;
  } exp_t;

  exp_t q[$];
  int   m_cnt;
  bit   m_sticky;

  alu_result_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .AMod(AMod), .BMod(BMod), .out_valid(out_valid), .out_ready(out_ready),
    .Res(Res), .Flags(Flags), .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky),
    .op_cnt(op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on the operand values
  function automatic exp_t calc(input int a, input int b);
    exp_t e;
    int sa, sb, s, u, r, c, v;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    s  = sa + sb;
    u  = a + b;
    c  = (u > 15) ? 1 : 0;
    v  = (s > 7 || s < -8) ? 1 : 0;
    r  = u % 16;
`ifdef ALU_RES_SAT_EN
    if (v == 1) r = (s > 7) ? 7 : 8;
`endif
    e.res   = r;
    e.flags = ((r == 0) ? 8 : 0) + c * 4 + v * 2 + ((r >= 8) ? 1 : 0);
    return e;
  endfunction

  task automatic check_all();
    check("in_ready", 32'(in_ready), (q.size() < 2) ? 1 : 0);
    check("out_valid", 32'(out_valid), (q.size() > 0) ? 1 : 0);
    check("Res", 32'(Res), (q.size() > 0) ? q[0].res : 0);
    check("Flags", 32'(Flags), (q.size() > 0) ? q[0].flags : 0);
    check("op_cnt", 32'(op_cnt), m_cnt);
    check("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
  endtask

  // Starts and ends at a negedge; checks current outputs, applies one edge of stimulus
  task automatic do_cycle(input bit r, input bit iv, input int a, input int b,
                          input bit ordy, input bit clr);
    bit   do_push, do_pop;
    exp_t e;
    check_all();
    rst        = r;
    in_valid   = iv;
    AMod       = 4'(a);
    BMod       = 4'(b);
    out_ready  = ordy;
    clr_sticky = clr;
    e       = calc(a, b);
    do_push = iv && (q.size() < 2);
    do_pop  = ordy && (q.size() > 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_cnt    = 0;
      m_sticky = 0;
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end
      if (do_push) q.push_back(e);
      if (clr) m_sticky = 0;
      if (do_push && e.flags[1]) m_sticky = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; AMod = '0; BMod = '0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    m_cnt = 0; m_sticky = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_op_cnt", 32'(op_cnt), 0);
    check("rst_sticky", 32'(ovf_sticky), 0);
    check("rst_res", 32'(Res), 0);
    check("rst_flags", 32'(Flags), 0);

    // Wrap to zero: Z and C set
    do_cycle(0, 1, 15, 1, 1, 0);
    check("wrap_res", 32'(Res), 0);
    check("wrap_flags", 32'(Flags), 32'h0000000C);
    do_cycle(0, 0, 0, 0, 1, 0);
    check("cnt_after_pop", 32'(op_cnt), 1);

    // Positive overflow
    do_cycle(0, 1, 7, 1, 0, 0);
`ifdef ALU_RES_SAT_EN
    check("ovf_res", 32'(Res), 7);
    check("ovf_flags", 32'(Flags), 32'h00000002);
`else
    check("ovf_res", 32'(Res), 8);
    check("ovf_flags", 32'(Flags), 32'h00000003);
`endif
    check("ovf_sticky", 32'(ovf_sticky), 1);
    do_cycle(0, 0, 0, 0, 1, 1);
    check("sticky_clr", 32'(ovf_sticky), 0);

    // Fill, refuse a third push, then drain in order
    do_cycle(0, 1, 1, 2, 0, 0);
    do_cycle(0, 1, 3, 4, 0, 0);
    check("full_in_ready", 32'(in_ready), 0);
    do_cycle(0, 1, 5, 5, 0, 0);
    check("full_head", 32'(Res), 3);
    do_cycle(0, 0, 0, 0, 1, 0);
    check("second_head", 32'(Res), 7);
    do_cycle(0, 0, 0, 0, 1, 0);
    check("drained", 32'(out_valid), 0);

    // Push/pop at count 1, reach count 2, then reset discards
    do_cycle(0, 1, 1, 1, 0, 0);
    do_cycle(0, 1, 2, 2, 1, 0);
    do_cycle(0, 1, 3, 3, 1, 0);
    do_cycle(0, 1, 4, 1, 0, 0);
    check("pre_rst_full", 32'(in_ready), 0);
    do_cycle(1, 0, 0, 0, 1, 0);
    check("post_rst_valid", 32'(out_valid), 0);
    check("post_rst_cnt", 32'(op_cnt), 0);

    // 256 pops wrap the counter
    for (int i = 0; i < 256; i++) do_cycle(0, 1, i % 16, 1, 1, 0);
    do_cycle(0, 0, 0, 0, 1, 0);
    check("cnt_wrap", 32'(op_cnt), 0);

    // Set wins over clear in the same cycle
    do_cycle(0, 1, 7, 1, 1, 1);
    check("set_wins", 32'(ovf_sticky), 1);
    do_cycle(0, 0, 0, 0, 1, 0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 2000; i++) begin
      do_cycle(($urandom_range(63) == 0), 1'($urandom), int'($urandom_range(15)),
               int'($urandom_range(15)), 1'($urandom), ($urandom_range(7) == 0));
    end
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
